// File: rtl/spi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : spi_pkg                                                   |
// | Purpose  : Shared frame geometry, header bit positions and frame     |
// |            state encoding for the SPI minion stream bridge.          |
// | Ports    : none (package)                                            |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package spi_pkg;

  // Two header bits ride in front of every payload, in both directions.
  localparam int unsigned HDR_W = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } frame_state_e;

  function automatic int unsigned frame_len(input int unsigned data_w);
    return data_w + HDR_W;
  endfunction

  // MOSI header: {wr, rd}; MISO header: {c2s_flag, space_flag}.
  function automatic int unsigned wr_bit(input int unsigned n);
    return n - 1;
  endfunction

  function automatic int unsigned rd_bit(input int unsigned n);
    return n - 2;
  endfunction

  function automatic int unsigned c2s_flag_bit(input int unsigned n);
    return n - 1;
  endfunction

  function automatic int unsigned space_flag_bit(input int unsigned n);
    return n - 2;
  endfunction

endpackage : spi_pkg
`default_nettype wire

// File: rtl/spi_minion_stream_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : spi_minion_stream_if                                      |
// | Purpose  : val/rdy stream bundle between the SPI minion and the core.|
// | Ports    : s2c_msg/s2c_val/s2c_rdy  SPI-to-core stream               |
// |            c2s_msg/c2s_val/c2s_rdy  core-to-SPI stream               |
// |            modport master = minion side, modport slave = core side   |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
interface spi_minion_stream_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] s2c_msg;
  logic              s2c_val;
  logic              s2c_rdy;
  logic [DATA_W-1:0] c2s_msg;
  logic              c2s_val;
  logic              c2s_rdy;

  modport master (
    output s2c_msg, s2c_val, c2s_rdy,
    input  s2c_rdy, c2s_msg, c2s_val
  );

  modport slave (
    input  s2c_msg, s2c_val, c2s_rdy,
    output s2c_rdy, c2s_msg, c2s_val
  );
endinterface : spi_minion_stream_if
`default_nettype wire

// File: rtl/spi_stream_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : spi_stream_fifo                                           |
// | Purpose  : Synchronous val/rdy FIFO with occupancy count. Enqueue    |
// |            and dequeue may coincide even when full.                  |
// | Ports    : clk, reset           clock, sync active-high reset        |
// |            enq_val, enq_msg     write side (caller gates on space)   |
// |            deq_val, deq_rdy,    read side; deq_val = not empty       |
// |            deq_msg                                                   |
// |            count                current occupancy 0..DEPTH           |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module spi_stream_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enq_val,
  input  logic [DATA_W-1:0]        enq_msg,
  output logic                     deq_val,
  input  logic                     deq_rdy,
  output logic [DATA_W-1:0]        deq_msg,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int c_AW = $clog2(DEPTH);
  localparam logic [c_AW:0] c_FULL = (c_AW+1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]   r_wr_ptr;
  logic [c_AW-1:0]   r_rd_ptr;
  logic [c_AW:0]     r_count;
  logic              w_deq;
  logic              w_enq;

  assign deq_val = (r_count != '0);
  assign deq_msg = r_mem[r_rd_ptr];
  assign count   = r_count;

  assign w_deq = deq_val & deq_rdy;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign w_enq = enq_val & ((r_count != c_FULL) | w_deq);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_enq) begin
        r_mem[r_wr_ptr] <= enq_msg;
        r_wr_ptr        <= r_wr_ptr + c_AW'(1);
      end
      if (w_deq) r_rd_ptr <= r_rd_ptr + c_AW'(1);
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + (c_AW+1)'(1);
        2'b01:   r_count <= r_count - (c_AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule : spi_stream_fifo
`default_nettype wire

// File: rtl/spi_minion_stream.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : spi_minion_stream                                         |
// | Purpose  : SPI mode-0 minion converting fixed-length frames into     |
// |            val/rdy streams, with per-direction FIFOs, flow-control   |
// |            flags, frame-length checking, overflow count and parity.  |
// | Ports    : clk, reset                 system clock, sync reset       |
// |            spi_cs/sclk/mosi/miso      pad-side SPI (async inputs)    |
// |            strm (master modport)      s2c / c2s val/rdy streams      |
// |            parity                     XOR of last committed write    |
// |            ovf_cnt, frame_err_cnt     saturating error counters      |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module spi_minion_stream
  import spi_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                spi_cs,
  input  logic                spi_sclk,
  input  logic                spi_mosi,
  output logic                spi_miso,
  spi_minion_stream_if.master strm,
  output logic                parity,
  output logic [CNT_W-1:0]    ovf_cnt,
  output logic [CNT_W-1:0]    frame_err_cnt
);
  localparam int c_N              = frame_len(DATA_W);
  localparam int c_WR_BIT         = wr_bit(c_N);
  localparam int c_RD_BIT         = rd_bit(c_N);
  localparam int c_C2S_FLAG_BIT   = c2s_flag_bit(c_N);
  localparam int c_SPACE_FLAG_BIT = space_flag_bit(c_N);
  localparam int c_BCW            = $clog2(c_N + 2);
  localparam int c_FCW            = $clog2(DEPTH) + 1;
  localparam logic [c_BCW-1:0] c_BIT_N   = c_BCW'(c_N);
  localparam logic [c_BCW-1:0] c_BIT_MAX = c_BCW'(c_N + 1);
  localparam logic [c_FCW-1:0] c_FULL    = c_FCW'(DEPTH);

  // Synchronizers reset to the idle bus levels so no edge appears after reset.
  logic [1:0] r_cs_sync, r_sclk_sync, r_mosi_sync;
  logic       r_cs_prev, r_sclk_prev;
  logic       w_cs_fall, w_cs_rise, w_sclk_rise, w_sclk_fall;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cs_sync   <= 2'b11;
      r_sclk_sync <= 2'b00;
      r_mosi_sync <= 2'b00;
      r_cs_prev   <= 1'b1;
      r_sclk_prev <= 1'b0;
    end else begin
      r_cs_sync   <= {r_cs_sync[0], spi_cs};
      r_sclk_sync <= {r_sclk_sync[0], spi_sclk};
      r_mosi_sync <= {r_mosi_sync[0], spi_mosi};
      r_cs_prev   <= r_cs_sync[1];
      r_sclk_prev <= r_sclk_sync[1];
    end
  end

  assign w_cs_fall   =  r_cs_prev   & ~r_cs_sync[1];
  assign w_cs_rise   = ~r_cs_prev   &  r_cs_sync[1];
  assign w_sclk_rise = ~r_sclk_prev &  r_sclk_sync[1];
  assign w_sclk_fall =  r_sclk_prev & ~r_sclk_sync[1];

  frame_state_e      r_state;
  logic [c_N-1:0]    r_rx;
  logic [c_N-1:0]    r_miso_sr;
  logic [c_BCW-1:0]  r_bit_cnt;
  logic              r_c2s_flag, r_space_flag, r_parity;
  logic [CNT_W-1:0]  r_ovf_cnt, r_ferr_cnt;

  logic [c_FCW-1:0]  w_s2c_count, w_c2s_count;
  logic              w_c2s_nonempty;
  logic [DATA_W-1:0] w_c2s_head;
  logic [c_N-1:0]    w_miso_load;
  logic              w_commit, w_frame_ok, w_frame_bad;
  logic              w_push, w_drop, w_pop;
  logic [DATA_W-1:0] w_data;

  // Commit decisions are taken in the very cycle the CS rise is seen.
  assign w_commit    = (r_state == SHIFT) & w_cs_rise;
  assign w_frame_ok  = w_commit & (r_bit_cnt == c_BIT_N);
  assign w_frame_bad = w_commit & (r_bit_cnt != '0) & (r_bit_cnt != c_BIT_N);
  assign w_data      = r_rx[DATA_W-1:0];
  // Flags were latched at CS fall; the s2c FIFO can only drain since then,
  // so a flagged-space write is always accepted.
  assign w_push      = w_frame_ok &  r_rx[c_WR_BIT] &  r_space_flag;
  assign w_drop      = w_frame_ok &  r_rx[c_WR_BIT] & ~r_space_flag;
  assign w_pop       = w_frame_ok &  r_rx[c_RD_BIT] &  r_c2s_flag;

  always_comb begin
    w_miso_load                    = '0;
    w_miso_load[c_C2S_FLAG_BIT]    = w_c2s_nonempty;
    w_miso_load[c_SPACE_FLAG_BIT]  = (w_s2c_count < c_FULL);
    w_miso_load[DATA_W-1:0]        = w_c2s_nonempty ? w_c2s_head : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_rx         <= '0;
      r_miso_sr    <= '0;
      r_bit_cnt    <= '0;
      r_c2s_flag   <= 1'b0;
      r_space_flag <= 1'b0;
      r_parity     <= 1'b0;
      r_ovf_cnt    <= '0;
      r_ferr_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_cs_fall) begin
            r_state      <= SHIFT;
            r_c2s_flag   <= w_miso_load[c_C2S_FLAG_BIT];
            r_space_flag <= w_miso_load[c_SPACE_FLAG_BIT];
            r_miso_sr    <= w_miso_load;
            r_rx         <= '0;
            r_bit_cnt    <= '0;
          end
        end
        SHIFT: begin
          if (w_cs_rise) begin
            r_state <= COMMIT;
          end else begin
            if (w_sclk_rise) begin
              r_rx <= {r_rx[c_N-2:0], r_mosi_sync[1]};
              if (r_bit_cnt != c_BIT_MAX) r_bit_cnt <= r_bit_cnt + c_BCW'(1);
            end
            if (w_sclk_fall) r_miso_sr <= {r_miso_sr[c_N-2:0], 1'b0};
          end
        end
        COMMIT:  r_state <= IDLE;
        default: r_state <= IDLE;
      endcase

      if (w_push) r_parity <= ^w_data;
      if (w_drop && (r_ovf_cnt != '1)) r_ovf_cnt <= r_ovf_cnt + CNT_W'(1);
      if (w_frame_bad && (r_ferr_cnt != '1)) r_ferr_cnt <= r_ferr_cnt + CNT_W'(1);
    end
  end

  assign spi_miso      = (r_state == SHIFT) & r_miso_sr[c_N-1];
  assign parity        = r_parity;
  assign ovf_cnt       = r_ovf_cnt;
  assign frame_err_cnt = r_ferr_cnt;
  assign strm.c2s_rdy  = (w_c2s_count != c_FULL);

  spi_stream_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_s2c_fifo (
    .clk     (clk),
    .reset   (reset),
    .enq_val (w_push),
    .enq_msg (w_data),
    .deq_val (strm.s2c_val),
    .deq_rdy (strm.s2c_rdy),
    .deq_msg (strm.s2c_msg),
    .count   (w_s2c_count)
  );

  spi_stream_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_c2s_fifo (
    .clk     (clk),
    .reset   (reset),
    .enq_val (strm.c2s_val & strm.c2s_rdy),
    .enq_msg (strm.c2s_msg),
    .deq_val (w_c2s_nonempty),
    .deq_rdy (w_pop),
    .deq_msg (w_c2s_head),
    .count   (w_c2s_count)
  );
endmodule : spi_minion_stream
`default_nettype wire

// File: doc/spi_minion_stream.md
Name: spi_minion_stream

Overview:
- Next-generation parametrised SPI minion. Converts fixed-length SPI frames into val/rdy streams in both directions, with per-direction FIFOs and flow-control flags in every frame.
- Adds frame-length checking, overflow counting and data parity.
- Sits between chip pads (cs/sclk/mosi/miso) and a core accelerator such as the FFT. Replaces the fixed three-port minion logic.

Parameters:
- DATA_W, 8, payload bits per frame; frame length N = DATA_W+2.
- DEPTH, 2, entries in each FIFO (power of two, >=2).
- CNT_W, 8, width of the saturating error counters.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- spi_cs  in  1  chip select, active low, asynchronous to clk.
- spi_sclk  in  1  SPI clock, mode 0, asynchronous.
- spi_mosi  in  1  master-out data, MSB first.
- spi_miso  out  1  minion-out data, MSB first.
- s2c_msg  out  DATA_W  SPI-to-core payload.
- s2c_val  out  1  s2c_msg valid.
- s2c_rdy  in  1  core accepts s2c_msg.
- c2s_msg  in  DATA_W  core-to-SPI payload.
- c2s_val  in  1  c2s_msg valid.
- c2s_rdy  out  1  block accepts c2s_msg; equals c2s FIFO not full.
- parity  out  1  XOR of the last committed write payload.
- ovf_cnt  out  CNT_W  saturating count of dropped writes.
- frame_err_cnt  out  CNT_W  saturating count of bad-length frames.

Behaviour:
- Inputs: spi_cs, spi_sclk and spi_mosi each pass through a 2-flop synchronizer. Edges are detected on the synchronized copies.
- SCLK timing: each SCLK phase must last >=4 clk cycles.
- MOSI frame, bit N-1 down to 0: {wr, rd, data[DATA_W-1:0]}.
- MISO frame: {c2s_flag, space_flag, resp[DATA_W-1:0]}.
- Frame start: on CS falling edge, latch:
  - c2s_flag = c2s FIFO nonempty;
  - space_flag = s2c FIFO count < DEPTH;
  - resp = c2s FIFO head, or 0 if empty.
  - Load the MISO shift register with these and clear the bit counter.
- Shifting:
  - On each SCLK rising edge while CS is low, shift spi_mosi into the receive register and increment the bit counter, saturating at N+1.
  - On each SCLK falling edge, shift MISO left. spi_miso = shift-register MSB.
  - spi_miso = 0 while CS is high.
- Commit: in the cycle the CS rising edge is detected:
  - count==N: commit.
    - wr=1 and space_flag=1: push data into the s2c FIFO and set parity = ^data.
    - wr=1 and space_flag=0: drop data and increment ovf_cnt.
    - rd=1 and c2s_flag=1: pop the c2s FIFO.
    - rd=1 and c2s_flag=0: no effect.
  - 0<count!=N: discard the frame and increment frame_err_cnt. No FIFO effect.
  - count==0: ignore silently.
- The space flag is a guarantee: the s2c FIFO can only drain between CS fall and CS rise, so a flagged-space write always succeeds.
- The c2s head is stable from CS fall to commit, because only the commit pops the c2s FIFO.
- Latency: a committed payload appears on s2c_val/s2c_msg in the cycle after commit.
- s2c_val = s2c FIFO nonempty. Transfer occurs when val && rdy.
- Both FIFOs support enqueue and dequeue in the same cycle when full. The count is unchanged and the order is preserved.
- Counters saturate at 2^CNT_W-1.
- Reset values: all FIFOs empty; s2c_val=0; c2s_rdy=1 from the cycle after reset deasserts; spi_miso=0; parity=0; both counters 0; shift registers and bit counter 0.
- Synchronizers reset to the idle levels cs=1, sclk=0, mosi=0, so no false edge is seen after reset.
- Reset mid-frame aborts the frame with no commit and no error count. The next CS fall starts cleanly.
- CS rising with no SCLK pulses is not an error.

Decomposition:
- Shared package spi_pkg:
  - header bit positions (WR_BIT=N-1, RD_BIT=N-2, C2S_FLAG_BIT, SPACE_FLAG_BIT);
  - function frame_len(DATA_W);
  - enum for the frame state {IDLE, SHIFT, COMMIT}.
- State transitions:
  - IDLE->SHIFT on CS fall;
  - SHIFT->COMMIT on CS rise;
  - COMMIT->IDLE unconditionally, in one cycle.
- One sub-module: spi_stream_fifo (parametrised DATA_W/DEPTH synchronous val/rdy FIFO with count output), instantiated twice.
- Synchronizers stay inline.

Test Plan (DATA_W=8, N=10, DEPTH=2):
1. Frame 10'b10_10100101 -> s2c_msg=0xA5, s2c_val=1 one cycle after commit, parity=0; MISO frame reads 10'b01_00000000.
2. Core pushes 0x3C, then frame 10'b01_00000000 -> MISO reads 10'b11_00111100; c2s FIFO empty after commit; c2s_rdy=1.
3. s2c_rdy=0; send writes 0x11 and 0x22, then write 0x33 -> third frame MISO space_flag=0, 0x33 dropped, ovf_cnt=1; s2c outputs 0x11 then 0x22 once s2c_rdy=1.
4. 7-bit frame, then 12-bit frame -> no FIFO change, frame_err_cnt=2; next 10-bit write 0x0F commits, parity=0.
5. reset asserted after 5 SCLK bits -> all outputs at reset values; following write 0x80 commits with parity=1 and frame_err_cnt=0.
6. s2c FIFO full (0x01, 0x02); during the third frame (space_flag=0 latched) pop one entry; commit write 0x03 -> dropped (ovf_cnt=1); s2c outputs 0x02 only, confirming the space flag is latched at CS fall.
